// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit for the single-bus datapath
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        CONin,
  output logic        InPortout,
  output logic        OutPortin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  alu_op
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  state_t state, next, last, done;
  logic [4:0] op;
  logic is_ld, is_ldi, is_st, is_mem, is_rr, is_imm, is_md, is_nn, is_br, is_jal, is_jr;
  logic is_in, is_out, is_mflo, is_mfhi, is_halt, is_exec, is_alu, waiting;
  logic unused_ir;
  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_ld     = op == 5'd0;
  assign is_ldi    = op == 5'd1;
  assign is_st     = op == 5'd2;
  assign is_mem    = op <= 5'd2;
  assign is_rr     = op >= 5'd3 && op <= 5'd11;
  assign is_imm    = op >= 5'd12 && op <= 5'd14;
  assign is_md     = op == 5'd15 || op == 5'd16;
  assign is_nn     = op == 5'd17 || op == 5'd18;
  assign is_br     = op == 5'd19;
  assign is_jal    = op == 5'd20;
  assign is_jr     = op == 5'd21;
  assign is_in     = op == 5'd22;
  assign is_out    = op == 5'd23;
  assign is_mflo   = op == 5'd24;
  assign is_mfhi   = op == 5'd25;
  assign is_halt   = op == 5'd27;
  assign is_exec   = op <= 5'd25;
  assign is_alu    = op >= 5'd3 && op <= 5'd18;
  assign waiting   = !mem_ready && (state == T1 || (state == T6 && is_ld) || (state == T7 && is_st));
  assign done      = stop ? IDLE : T0;
  assign last      = (is_jr | is_in | is_out | is_mflo | is_mfhi) ? T3 :
                     (is_jal | is_nn) ? T4 :
                     (is_rr | is_imm | is_ldi) ? T5 :
                     (is_md | is_br) ? T6 : T7;
  // State register; clear drops the controller to IDLE without waiting for a clock
  always_ff @(posedge clock or negedge clear)
    if (!clear) state <= IDLE;
    else        state <= next;
  // Step sequencing: memory waits hold, the class's last step returns to fetch or idle
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = stop ? IDLE : T0;
      HALT:    next = HALT;
      T2:      next = is_halt ? HALT : is_exec ? T3 : done;
      default: next = waiting ? state : state == last ? done : state_t'(state + 4'd1);
    endcase
  end
  // Control word decode from the current step and the instruction class
  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zhighout, Zlowout,
     HIin, LOin, HIout, LOout, Cout, CONin, InPortout, OutPortin, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    run    = state != IDLE && state != HALT;
    alu_op = !run ? 5'd0 : (state >= T3 && is_alu) ? op : 5'd3;
    case (state)
      T0: {PCout, MARin, IncPC, Zin} = '1;
      T1: {Zlowout, PCin, Read, MDRin} = '1;
      T2: {MDRout, IRin} = '1;
      T3:
        if (is_rr | is_imm)  {Grb, Rout, Yin} = '1;
        else if (is_nn)      {Grb, Rout, Zin} = '1;
        else if (is_md)      {Gra, Rout, Yin} = '1;
        else if (is_mem)     {Grb, BAout, Yin} = '1;
        else if (is_br)      {Gra, Rout, CONin} = '1;
        else if (is_jr)      {Gra, Rout, PCin} = '1;
        else if (is_jal)     {PCout, Grb, Rin} = '1;
        else if (is_in)      {InPortout, Gra, Rin} = '1;
        else if (is_out)     {Gra, Rout, OutPortin} = '1;
        else if (is_mflo)    {LOout, Gra, Rin} = '1;
        else if (is_mfhi)    {HIout, Gra, Rin} = '1;
      T4:
        if (is_rr)                  {Grc, Rout, Zin} = '1;
        else if (is_imm | is_mem)   {Cout, Zin} = '1;
        else if (is_nn)             {Zlowout, Gra, Rin} = '1;
        else if (is_md)             {Grb, Rout, Zin} = '1;
        else if (is_br)             {PCout, Yin} = '1;
        else if (is_jal)            {Gra, Rout, PCin} = '1;
      T5:
        if (is_rr | is_imm | is_ldi) {Zlowout, Gra, Rin} = '1;
        else if (is_md)              {Zlowout, LOin} = '1;
        else if (is_ld | is_st)      {Zlowout, MARin} = '1;
        else if (is_br)              {Cout, Zin} = '1;
      T6:
        if (is_md)                   {Zhighout, HIin} = '1;
        else if (is_ld)              {Read, MDRin} = '1;
        else if (is_st)              {Gra, Rout, MDRin} = '1;
        else if (is_br && con_ff)    {Zlowout, PCin} = '1;
      T7:
        if (is_ld)                   {MDRout, Gra, Rin} = '1;
        else if (is_st)              Write = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized and directed checks of the control sequencer against a step-list model
module tb_control_sequencer;
  logic clock = 0, clear = 0, con_ff = 0, mem_ready = 1, stop = 0;
  logic [31:0] ir = 0;
  logic run, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zhighout, Zlowout;
  logic HIin, LOin, HIout, LOout, Cout, CONin, InPortout, OutPortin, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] alu_op;
  logic [27:0] obs;
  int tests = 0, failed = 0;

  localparam logic [27:0] PCOUT = 28'h1 << 0,  PCIN = 28'h1 << 1,   INCPC = 28'h1 << 2,  MARIN = 28'h1 << 3;
  localparam logic [27:0] MDRIN = 28'h1 << 4,  MDROUT = 28'h1 << 5, READ = 28'h1 << 6,   WRITE = 28'h1 << 7;
  localparam logic [27:0] IRIN = 28'h1 << 8,   YIN = 28'h1 << 9,    ZIN = 28'h1 << 10,   ZHI = 28'h1 << 11;
  localparam logic [27:0] ZLO = 28'h1 << 12,   HIIN = 28'h1 << 13,  LOIN = 28'h1 << 14,  HIOUT = 28'h1 << 15;
  localparam logic [27:0] LOOUT = 28'h1 << 16, COUT = 28'h1 << 17,  CONIN = 28'h1 << 18, INP = 28'h1 << 19;
  localparam logic [27:0] OUTP = 28'h1 << 20,  GRA = 28'h1 << 21,   GRB = 28'h1 << 22,   GRC = 28'h1 << 23;
  localparam logic [27:0] RIN = 28'h1 << 24,   ROUT = 28'h1 << 25,  BAOUT = 28'h1 << 26, RUN = 28'h1 << 27;

  typedef struct packed {logic [27:0] c; logic [4:0] a; logic w;} step_t;
  step_t exp_q[$];

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .stop(stop),
    .run(run), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin), .HIout(HIout),
    .LOout(LOout), .Cout(Cout), .CONin(CONin), .InPortout(InPortout), .OutPortin(OutPortin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_op(alu_op)
  );

  assign obs = {run, BAout, Rout, Rin, Grc, Grb, Gra, OutPortin, InPortout, CONin, Cout, LOout, HIout,
                LOin, HIin, Zlowout, Zhighout, Zin, Yin, IRin, Write, Read, MDRout, MDRin, MARin,
                IncPC, PCin, PCout};

  always #5 clock = ~clock;

  function automatic void push(input logic [27:0] c, input logic [4:0] a, input logic w);
    exp_q.push_back({RUN | c, a, w});
  endfunction

  // Expected per-cycle control words of one instruction with no memory waits
  function automatic void build(input logic [4:0] op, input logic con);
    logic [4:0] a;
    a = (op >= 3 && op <= 18) ? op : 5'd3;
    exp_q.delete();
    push(PCOUT | MARIN | INCPC | ZIN, 3, 0);
    push(ZLO | PCIN | READ | MDRIN, 3, 1);
    push(MDROUT | IRIN, 3, 0);
    if (op <= 2) begin
      push(GRB | BAOUT | YIN, a, 0);
      push(COUT | ZIN, a, 0);
    end
    if (op == 0) begin
      push(ZLO | MARIN, a, 0); push(READ | MDRIN, a, 1); push(MDROUT | GRA | RIN, a, 0);
    end
    if (op == 1) push(ZLO | GRA | RIN, a, 0);
    if (op == 2) begin
      push(ZLO | MARIN, a, 0); push(GRA | ROUT | MDRIN, a, 0); push(WRITE, a, 1);
    end
    if (op >= 3 && op <= 14) begin
      push(GRB | ROUT | YIN, a, 0);
      push(op <= 11 ? (GRC | ROUT | ZIN) : (COUT | ZIN), a, 0);
      push(ZLO | GRA | RIN, a, 0);
    end
    if (op == 15 || op == 16) begin
      push(GRA | ROUT | YIN, a, 0); push(GRB | ROUT | ZIN, a, 0);
      push(ZLO | LOIN, a, 0); push(ZHI | HIIN, a, 0);
    end
    if (op == 17 || op == 18) begin
      push(GRB | ROUT | ZIN, a, 0); push(ZLO | GRA | RIN, a, 0);
    end
    if (op == 19) begin
      push(GRA | ROUT | CONIN, a, 0); push(PCOUT | YIN, a, 0); push(COUT | ZIN, a, 0);
      push(con ? (ZLO | PCIN) : 28'h0, a, 0);
    end
    if (op == 20) begin
      push(PCOUT | GRB | RIN, a, 0); push(GRA | ROUT | PCIN, a, 0);
    end
    if (op == 21) push(GRA | ROUT | PCIN, a, 0);
    if (op == 22) push(INP | GRA | RIN, a, 0);
    if (op == 23) push(GRA | ROUT | OUTP, a, 0);
    if (op == 24) push(LOOUT | GRA | RIN, a, 0);
    if (op == 25) push(HIOUT | GRA | RIN, a, 0);
  endfunction

  // Drives one instruction from T0 and checks every cycle; waitable steps are stretched by w1 (fetch) or w2
  task automatic exec(input logic [4:0] op, input logic con, input int w1, input int w2,
                      input int max_steps, input int stop_at, input string name);
    int used, nw;
    used = 0;
    build(op, con);
    for (int i = 0; i < exp_q.size() && used < max_steps; i++) begin
      nw = exp_q[i].w ? (i == 1 ? w1 : w2) : 0;
      for (int j = 0; j <= nw && used < max_steps; j++) begin
        @(negedge clock);
        if (used == 0) begin
          ir = {op, 27'($urandom)};
          con_ff = con;
        end
        mem_ready = exp_q[i].w ? (j == nw) : 1'($urandom);
        tests++;
        if ({obs, alu_op} !== {exp_q[i].c, exp_q[i].a}) begin
          failed++;
          $display("FAIL %s op=%0d cycle=%0d: got ctl=%h alu=%h, expected ctl=%h alu=%h",
                   name, op, used, obs, alu_op, exp_q[i].c, exp_q[i].a);
        end
        if (used == stop_at) stop = 1;
        used++;
      end
    end
  endtask

  task automatic check_quiet(input string name);
    tests++;
    if (obs !== 28'h0 || alu_op !== 5'd0) begin
      failed++;
      $display("FAIL %s: got ctl=%h alu=%h, expected ctl=0 alu=0", name, obs, alu_op);
    end
  endtask

  task automatic reset_dut();
    clear = 0; stop = 0; mem_ready = 1;
    @(negedge clock);
    clear = 1;
  endtask

  task automatic test_reset();
    clear = 0;
    repeat (3) begin
      @(negedge clock);
      stop = 1'($urandom); mem_ready = 1'($urandom);
      check_quiet("reset_hold");
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    exec(16, 0, 0, 0, 6, -1, "mul_pre_reset");
    #1 clear = 0;
    #1 check_quiet("reset_async");
    @(negedge clock);
    check_quiet("reset_held_edge");
    clear = 1;
    exec(3, 0, 0, 0, 1000, -1, "after_reset");
  endtask

  task automatic test_add();
    reset_dut();
    exec(3, 0, 0, 0, 1000, -1, "add");
    exec(26, 0, 0, 0, 1000, -1, "add_next_t0");
  endtask

  task automatic test_ld_wait();
    reset_dut();
    exec(0, 0, 1, 2, 1000, -1, "ld_wait");
    exec(2, 0, 0, 2, 1000, -1, "st_wait");
    exec(26, 0, 0, 0, 1000, -1, "ld_next");
  endtask

  task automatic test_br();
    reset_dut();
    exec(19, 0, 0, 0, 1000, -1, "br_not_taken");
    exec(19, 1, 0, 0, 1000, -1, "br_taken");
    exec(20, 0, 0, 0, 1000, -1, "jal");
    exec(26, 0, 0, 0, 1000, -1, "br_next");
  endtask

  task automatic test_halt();
    reset_dut();
    exec(27, 0, 0, 0, 1000, -1, "halt_fetch");
    repeat (20) begin
      @(negedge clock);
      stop = 1'($urandom); mem_ready = 1'($urandom);
      check_quiet("halt_quiet");
    end
  endtask

  task automatic test_stop();
    reset_dut();
    exec(26, 0, 0, 0, 1000, 1, "nop_stop");
    repeat (3) begin
      @(negedge clock);
      check_quiet("stop_idle");
    end
    stop = 0;
    exec(0, 0, 0, 0, 1000, 3, "ld_stop_mid");
    repeat (2) begin
      @(negedge clock);
      check_quiet("stop_idle_ld");
    end
    stop = 0;
    exec(26, 0, 0, 0, 1000, -1, "resume");
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    reset_dut();
    for (int n = 0; n < 80; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 27) op = 5'd26;
      exec(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1000, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_add();
    test_ld_wait();
    test_br();
    test_halt();
    test_stop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
